// File: rtl/bip_debug_ctrl.sv
// UART-side debug controller for the BIP CPU: loads program words, runs or
// single-steps the core, and reports a {PC, ACC, cycle count} snapshot.
module bip_debug_ctrl #(
  parameter int NBITS_0 = 11,
  parameter int NBITS_D = 16,
  parameter int OPCODE  = 5
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [7:0]         i_rx_data,
  input  logic               i_rx_valid,
  output logic [7:0]         o_tx_data,
  output logic               o_tx_valid,
  input  logic               i_tx_ready,
  output logic               o_prog_we,
  output logic [NBITS_0-1:0] o_prog_addr,
  output logic [NBITS_D-1:0] o_prog_data,
  output logic               o_cpu_en,
  output logic               o_cpu_rst,
  input  logic [NBITS_0-1:0] i_cpu_pc,
  input  logic [NBITS_D-1:0] i_cpu_acc,
  input  logic [OPCODE-1:0]  i_cpu_opcode
);

  typedef enum logic [2:0] {IDLE, LOAD_HI, LOAD_LO, RUN, STEP, DUMP} state_t;

  state_t              r_state, w_state_next;
  logic [7:0]          r_tx_data, w_tx_data_next;
  logic                r_tx_valid, w_tx_valid_next;
  logic                r_prog_we, w_prog_we_next;
  logic [NBITS_0-1:0]  r_prog_addr, w_prog_addr_next;
  logic [NBITS_D-1:0]  r_prog_data, w_prog_data_next;
  logic                r_cpu_en, w_cpu_en_next;
  logic                r_cpu_rst, w_cpu_rst_next;
  logic [NBITS_0-1:0]  r_wr_addr, w_wr_addr_next;
  logic [7:0]          r_hi, w_hi_next;
  logic [15:0]         r_cnt, w_cnt_next;
  logic [47:0]         r_snap, w_snap_next;
  logic [2:0]          r_idx, w_idx_next;
  logic                r_armed, w_armed_next;

  logic [NBITS_D-1:0]  w_word;
  logic [OPCODE-1:0]   w_word_opc;
  logic [47:0]         w_snap_now;
  logic [47:0]         w_snap_shift;

  assign w_word       = NBITS_D'({r_hi, i_rx_data});
  assign w_word_opc   = w_word[NBITS_D-1 -: OPCODE];
  assign w_snap_now   = {16'(i_cpu_pc), 16'(i_cpu_acc), r_cnt};
  assign w_snap_shift = r_snap << (6'd8 * (6'(r_idx) + 6'd1));

  always_comb begin
    w_state_next     = r_state;
    w_tx_data_next   = r_tx_data;
    w_tx_valid_next  = r_tx_valid;
    w_prog_we_next   = 1'b0;
    w_prog_addr_next = r_prog_addr;
    w_prog_data_next = r_prog_data;
    w_cpu_en_next    = 1'b0;
    w_cpu_rst_next   = 1'b0;
    w_wr_addr_next   = r_wr_addr;
    w_hi_next        = r_hi;
    w_cnt_next       = r_cnt;
    w_snap_next      = r_snap;
    w_idx_next       = r_idx;
    w_armed_next     = r_armed;
    if (r_cpu_en && r_cnt != 16'hFFFF) w_cnt_next = r_cnt + 16'd1;

    case (r_state)
      IDLE: if (i_rx_valid) begin
        case (i_rx_data)
          8'h4C: begin
            w_cpu_rst_next = 1'b1;
            w_wr_addr_next = '0;
            w_state_next   = LOAD_HI;
          end
          8'h43: begin
            w_cpu_rst_next = 1'b1;
            w_cnt_next     = '0;
            w_state_next   = RUN;
          end
          8'h53: begin
            w_cpu_en_next = 1'b1;
            w_state_next  = STEP;
          end
          default: ;
        endcase
      end
      LOAD_HI: if (i_rx_valid) begin
        w_hi_next    = i_rx_data;
        w_state_next = LOAD_LO;
      end
      LOAD_LO: if (i_rx_valid) begin
        w_prog_we_next   = 1'b1;
        w_prog_addr_next = r_wr_addr;
        w_prog_data_next = w_word;
        w_wr_addr_next   = r_wr_addr + 1'b1;
        if (w_word_opc == '0 || r_wr_addr == '1) w_state_next = IDLE;
        else                                     w_state_next = LOAD_HI;
      end
      RUN: begin
        // The halting cycle is still enabled; stop enabling from the next one.
        if (r_cpu_en && i_cpu_opcode == '0) begin
          w_armed_next = 1'b0;
          w_state_next = DUMP;
        end else begin
          w_cpu_en_next = 1'b1;
        end
      end
      STEP: begin
        w_armed_next = 1'b0;
        w_state_next = DUMP;
      end
      DUMP: begin
        // Snapshot one cycle after the last enable so the CPU state has settled.
        if (!r_armed) begin
          w_snap_next     = w_snap_now;
          w_tx_data_next  = w_snap_now[47:40];
          w_tx_valid_next = 1'b1;
          w_idx_next      = '0;
          w_armed_next    = 1'b1;
        end else if (r_tx_valid && i_tx_ready) begin
          if (r_idx == 3'd5) begin
            w_tx_valid_next = 1'b0;
            w_state_next    = IDLE;
          end else begin
            w_idx_next     = r_idx + 3'd1;
            w_tx_data_next = w_snap_shift[47:40];
          end
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state     <= IDLE;
      r_tx_data   <= '0;
      r_tx_valid  <= 1'b0;
      r_prog_we   <= 1'b0;
      r_prog_addr <= '0;
      r_prog_data <= '0;
      r_cpu_en    <= 1'b0;
      r_cpu_rst   <= 1'b1;
      r_wr_addr   <= '0;
      r_hi        <= '0;
      r_cnt       <= '0;
      r_snap      <= '0;
      r_idx       <= '0;
      r_armed     <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_tx_data   <= w_tx_data_next;
      r_tx_valid  <= w_tx_valid_next;
      r_prog_we   <= w_prog_we_next;
      r_prog_addr <= w_prog_addr_next;
      r_prog_data <= w_prog_data_next;
      r_cpu_en    <= w_cpu_en_next;
      r_cpu_rst   <= w_cpu_rst_next;
      r_wr_addr   <= w_wr_addr_next;
      r_hi        <= w_hi_next;
      r_cnt       <= w_cnt_next;
      r_snap      <= w_snap_next;
      r_idx       <= w_idx_next;
      r_armed     <= w_armed_next;
    end
  end

  assign o_tx_data   = r_tx_data;
  assign o_tx_valid  = r_tx_valid;
  assign o_prog_we   = r_prog_we;
  assign o_prog_addr = r_prog_addr;
  assign o_prog_data = r_prog_data;
  assign o_cpu_en    = r_cpu_en;
  assign o_cpu_rst   = r_cpu_rst;

endmodule

// File: tb/tb_bip_debug_ctrl.sv
// Directed bench for bip_debug_ctrl with a tiny CPU model that halts at PC=3.
module tb_bip_debug_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = '0;
  logic        rx_valid = 1'b0;
  logic        tx_ready = 1'b1;
  logic [7:0]  o_tx_data;
  logic        o_tx_valid;
  logic        o_prog_we;
  logic [10:0] o_prog_addr;
  logic [15:0] o_prog_data;
  logic        o_cpu_en;
  logic        o_cpu_rst;
  logic [10:0] cpu_pc = '0;
  logic [15:0] cpu_acc = '0;
  logic [4:0]  cpu_opc;

  int n_total = 0;
  int n_bad = 0;

  logic [7:0]  txq[$];
  logic [10:0] wa[$];
  logic [15:0] wd[$];
  int en_cnt = 0;
  int rst_cnt = 0;
  int overlap = 0;

  always #5 clk = ~clk;

  bip_debug_ctrl #(.NBITS_0(11), .NBITS_D(16), .OPCODE(5)) dut (
    .i_clock(clk), .i_reset(rst_n),
    .i_rx_data(rx_data), .i_rx_valid(rx_valid),
    .o_tx_data(o_tx_data), .o_tx_valid(o_tx_valid), .i_tx_ready(tx_ready),
    .o_prog_we(o_prog_we), .o_prog_addr(o_prog_addr), .o_prog_data(o_prog_data),
    .o_cpu_en(o_cpu_en), .o_cpu_rst(o_cpu_rst),
    .i_cpu_pc(cpu_pc), .i_cpu_acc(cpu_acc), .i_cpu_opcode(cpu_opc)
  );

  // CPU model: each executed instruction adds 6 to ACC; PC 3 holds a HLT.
  assign cpu_opc = (cpu_pc == 11'd3) ? 5'd0 : 5'd1;
  always @(posedge clk) begin
    if (o_cpu_rst) begin
      cpu_pc  <= '0;
      cpu_acc <= '0;
    end else if (o_cpu_en && cpu_opc != 5'd0) begin
      cpu_pc  <= cpu_pc + 11'd1;
      cpu_acc <= cpu_acc + 16'd6;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (o_prog_we) begin
        wa.push_back(o_prog_addr);
        wd.push_back(o_prog_data);
      end
      if (o_cpu_en) en_cnt++;
      if (o_cpu_en && o_prog_we) overlap++;
      if (o_cpu_rst) rst_cnt++;
      if (o_tx_valid && tx_ready) txq.push_back(o_tx_data);
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    txq.delete();
    wa.delete();
    wd.delete();
    en_cnt = 0;
    rst_cnt = 0;
    overlap = 0;
  endtask

  task automatic send(input logic [7:0] b);
    rx_data = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k;
    k = 0;
    while (txq.size() < n && k < budget) begin
      @(posedge clk); #1;
      k++;
    end
    if (txq.size() < n) chk("tx_timeout", txq.size(), n);
  endtask

  task automatic chk_dump(input string tag, input logic [47:0] exp);
    logic [47:0] e;
    e = exp;
    chk({tag, "_len"}, txq.size(), 6);
    for (int i = 0; i < 6 && i < txq.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), txq[i], e[47-8*i -: 8]);
  endtask

  initial begin
    int changes;
    int bad_addr;

    // Reset state
    idle(2);
    chk("rst_tx_valid", o_tx_valid, 0);
    chk("rst_tx_data", o_tx_data, 0);
    chk("rst_prog_we", o_prog_we, 0);
    chk("rst_prog_addr", o_prog_addr, 0);
    chk("rst_prog_data", o_prog_data, 0);
    chk("rst_cpu_en", o_cpu_en, 0);
    chk("rst_cpu_rst", o_cpu_rst, 1);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_cpu_rst_held", o_cpu_rst, 1);
    @(negedge clk);
    chk("rst_cpu_rst_drop", o_cpu_rst, 0);
    @(posedge clk); #1;
    clear_mon();

    // Unknown command ignored
    send(8'h58);
    idle(4);
    chk("x_rst", rst_cnt, 0);
    chk("x_we", wa.size(), 0);
    chk("x_en", en_cnt, 0);
    chk("x_tx", txq.size(), 0);

    // Load two words
    clear_mon();
    send(8'h4C); send(8'h08); send(8'h05); send(8'h00); send(8'h00);
    idle(3);
    chk("ld_count", wa.size(), 2);
    chk("ld_rst_pulse", rst_cnt, 1);
    if (wa.size() == 2) begin
      chk("ld_a0", wa[0], 11'h000);
      chk("ld_d0", wd[0], 16'h0805);
      chk("ld_a1", wa[1], 11'h001);
      chk("ld_d1", wd[1], 16'h0000);
    end

    // Run to HLT; RX bytes sent while running are ignored
    clear_mon();
    send(8'h43);
    send(8'h4C);
    send(8'h53);
    wait_tx(6, 200);
    idle(2);
    chk_dump("run", 48'h0003_0012_0004);
    chk("run_en", en_cnt, 4);
    chk("run_rst_pulse", rst_cnt, 1);
    chk("run_we", wa.size(), 0);
    chk("run_overlap", overlap, 0);

    // Single step
    clear_mon();
    send(8'h53);
    wait_tx(6, 100);
    idle(2);
    chk_dump("step1", 48'h0003_0012_0005);
    chk("step1_en", en_cnt, 1);

    // Single step with 10 cycles of back-pressure on the second byte
    clear_mon();
    send(8'h53);
    wait_tx(1, 100);
    tx_ready = 1'b0;
    changes = 0;
    repeat (10) begin
      @(negedge clk);
      if (o_tx_data !== 8'h03 || o_tx_valid !== 1'b1) changes++;
    end
    chk("bp_stable", changes, 0);
    chk("bp_held_count", txq.size(), 1);
    @(posedge clk); #1;
    tx_ready = 1'b1;
    wait_tx(6, 100);
    idle(2);
    chk_dump("step2", 48'h0003_0012_0006);
    chk("step2_en", en_cnt, 1);

    // Asynchronous reset at the third dump byte
    clear_mon();
    send(8'h53);
    wait_tx(2, 100);
    tx_ready = 1'b0;
    @(negedge clk);
    chk("ar_pre_valid", o_tx_valid, 1);
    chk("ar_pre_data", o_tx_data, 8'h00);
    #2 rst_n = 1'b0;
    #1;
    chk("ar_tx_valid", o_tx_valid, 0);
    chk("ar_cpu_rst", o_cpu_rst, 1);
    changes = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_tx_valid || o_cpu_en || o_prog_we) changes++;
    end
    chk("ar_quiet", changes, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    tx_ready = 1'b1;
    idle(2);
    clear_mon();
    send(8'h53);
    wait_tx(6, 100);
    idle(2);
    chk_dump("ar_step", 48'h0001_0006_0001);

    // Fill all 2048 addresses; loading must stop at 0x7FF without wrapping
    clear_mon();
    send(8'h4C);
    for (int i = 0; i < 2048; i++) begin
      logic [10:0] iv;
      iv = 11'(i);
      send(8'h08);
      send(iv[7:0]);
    end
    idle(3);
    chk("full_count", wa.size(), 2048);
    if (wa.size() == 2048) begin
      chk("full_first", wa[0], 11'h000);
      chk("full_last_addr", wa[2047], 11'h7FF);
      chk("full_last_data", wd[2047], 16'h08FF);
      bad_addr = 0;
      for (int i = 0; i < 2048; i++) if (wa[i] != 11'(i)) bad_addr++;
      chk("full_seq", bad_addr, 0);
    end
    send(8'h08);
    send(8'h00);
    idle(3);
    chk("full_nowrap", wa.size(), 2048);
    chk("full_en", en_cnt, 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/bip_debug_ctrl.md
BIP_DEBUG_CTRL -- requirements
Module: bip_debug_ctrl

Interface
REQ-001 Parameter NBITS_0, default 11, SHALL be the program address and PC width.
REQ-002 Parameter NBITS_D, default 16, SHALL be the instruction and accumulator width.
REQ-003 Parameter OPCODE, default 5, SHALL be the opcode width, taken from instruction bits [NBITS_D-1:NBITS_D-OPCODE].
REQ-004 i_clock  in  1  SHALL be the single clock; all state changes on its rising edge.
REQ-005 i_reset  in  1  SHALL be the reset: asynchronous, active-low.
REQ-006 i_rx_data  in  8  SHALL carry the received command or program byte.
REQ-007 i_rx_valid  in  1  SHALL be a one-cycle strobe meaning i_rx_data is valid; there is no back-pressure.
REQ-008 o_tx_data  out  8  SHALL carry the outgoing report byte.
REQ-009 o_tx_valid  out  1  SHALL mean o_tx_data is valid.
REQ-010 i_tx_ready  in  1  SHALL mean the transmitter accepts a byte; a byte transfers when o_tx_valid & i_tx_ready.
REQ-011 o_prog_we  out  1  SHALL be the program-memory write strobe.
REQ-012 o_prog_addr  out  NBITS_0  SHALL be the program-memory write address.
REQ-013 o_prog_data  out  NBITS_D  SHALL be the program-memory write data.
REQ-014 o_cpu_en  out  1  SHALL be the CPU clock-enable; the CPU advances one instruction per cycle it is high.
REQ-015 o_cpu_rst  out  1  SHALL be the active-high CPU reset, PC to 0.
REQ-016 i_cpu_pc  in  NBITS_0  SHALL be the current CPU PC.
REQ-017 i_cpu_acc  in  NBITS_D  SHALL be the current CPU accumulator.
REQ-018 i_cpu_opcode  in  OPCODE  SHALL be the opcode currently presented to the CPU decoder; 0 means HLT.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD_HI, LOAD_LO, RUN, STEP, DUMP.
REQ-020 In IDLE, command bytes arriving on i_rx_valid SHALL be handled as follows:
- 0x4C 'L': pulse o_cpu_rst for 1 cycle, clear the write address to 0, go to LOAD_HI.
- 0x43 'C': pulse o_cpu_rst for 1 cycle, clear the cycle counter, go to RUN on the next cycle.
- 0x53 'S': go to STEP.
- Any other byte: ignore.
REQ-021 In LOAD_HI, on i_rx_valid the controller SHALL latch the byte as the instruction high byte and go to LOAD_LO.
REQ-022 In LOAD_LO, on i_rx_valid the controller SHALL:
- drive o_prog_we=1 for exactly 1 cycle with o_prog_data={hi,lo} and o_prog_addr = the current address;
- then increment the address.
REQ-023 After the LOAD_LO write, the next state SHALL be IDLE if the written opcode is 0 or the address was 2^NBITS_0-1 (no wrap); otherwise LOAD_HI.
REQ-024 In RUN, o_cpu_en SHALL be 1 and the 16-bit cycle counter SHALL increment once per enabled cycle, saturating at 0xFFFF.
REQ-025 In RUN, when i_cpu_opcode==0 while o_cpu_en=1, that cycle SHALL be the last enabled cycle and still counts; the next state SHALL be DUMP.
REQ-026 STEP SHALL assert o_cpu_en for exactly one cycle and increment the counter (saturating), then go to DUMP; 'S' does not clear the counter.
REQ-027 On DUMP entry the controller SHALL snapshot {zero-extended PC to 16 bits, ACC, counter}.
REQ-028 DUMP SHALL send 6 bytes in order: PC[15:8], PC[7:0], ACC[15:8], ACC[7:0], CNT[15:8], CNT[7:0].
REQ-029 In DUMP, o_tx_valid SHALL stay high with o_tx_data stable until accepted; the next byte SHALL be presented the cycle after acceptance; after the 6th acceptance the state SHALL return to IDLE.
REQ-030 i_rx_valid bytes received in RUN, STEP or DUMP SHALL be ignored.
REQ-031 o_cpu_en and o_prog_we SHALL never be high in the same cycle; o_prog_we SHALL be asserted only in LOAD_LO.
REQ-032 All outputs SHALL be registered.

Reset
REQ-033 While i_reset=0 the controller SHALL be in state IDLE with: o_tx_valid=0, o_tx_data=0, o_prog_we=0, o_prog_addr=0, o_prog_data=0, o_cpu_en=0, o_cpu_rst=1, counter=0.
REQ-034 On reset release, o_cpu_rst SHALL drop on the first clock edge.
REQ-035 Reset asserted mid-load, mid-run or mid-dump SHALL abort immediately with no further write, enable or tx beat.

Verification
REQ-036 Load: 'L',0x08,0x05,0x00,0x00 -> writes addr0=0x0805, then addr1=0x0000; returns to IDLE; exactly 2 o_prog_we pulses.
REQ-037 Run: 'C' with a CPU model halting at PC=3 (ACC=0x0012) -> o_cpu_en high for 4 cycles; bytes 00,03,00,12,00,04 sent.
REQ-038 Step: 'S' twice after REQ-037 -> exactly one o_cpu_en cycle each; CNT bytes 00,05 then 00,06.
REQ-039 Back-pressure: hold i_tx_ready=0 for 10 cycles during DUMP -> o_tx_data unchanged and no byte skipped.
REQ-040 Boundaries: load 2048 nonzero-opcode words -> last write at 0x7FF, then IDLE with no wrap; 'X' in IDLE ignored; RX bytes during RUN ignored.
REQ-041 Async reset: i_reset=0 at the 3rd DUMP byte -> o_tx_valid=0 with no clock edge; after release the FSM is IDLE with counter 0.
